prog_loader: RTL



---
 rtl/prog_loader_pkg.sv | 29 ++
 rtl/prog_loader_if.sv | 29 ++
 rtl/prog_loader_byte_assembler.sv | 41 ++++
 rtl/prog_loader.sv | 107 ++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding,
// header field lengths and the header range check.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ENTRY = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        BOOT  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam int ENTRY_BYTES = 4;
    localparam int COUNT_BYTES = 4;
    localparam int WORD_BYTES  = 4;

    // True when a load of n words starting at base would write past cap.
    // Computed wide enough that neither the scaling nor the add can wrap.
    function automatic logic beyond_capacity(input logic [31:0] base,
                                             input logic [31:0] n,
                                             input logic [31:0] cap);
        logic [34:0] last_addr;
        last_addr = {3'b000, base} + {1'b0, (n - 32'd1), 2'b00};
        return (n != 32'd0) && (last_addr > {3'b000, cap});
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream handshake, memory write port and core boot controls of the
// program loader, bundled so the loader and its environment share one view.
interface prog_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] memAddr;
    logic [31:0] memIn;
    logic        memWrite;
    logic [31:0] entryPoint;
    logic        INT;
    logic        busy;
    logic        done;
    logic        err;

    // The loader side.
    modport master (
        input  byte_in, byte_valid,
        output byte_ready, memAddr, memIn, memWrite,
        output entryPoint, INT, busy, done, err
    );

    // The byte source plus the memory/core side.
    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, memAddr, memIn, memWrite,
        input  entryPoint, INT, busy, done, err
    );
endinterface

// File: rtl/prog_loader_byte_assembler.sv
// Collects BYTES stream bytes into a little-endian word. The first byte of a
// field ends up in bits [7:0]. word shows the value the register will hold
// once byte_in is taken, so the consumer can latch a complete field on the
// same edge that accepts its last byte (flagged by word_full).
module byte_assembler
    import prog_loader_pkg::*;
#(
    parameter int BYTES = WORD_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        take,
    output logic [31:0] word,
    output logic        word_full
);

    localparam logic [1:0] LAST = 2'(BYTES - 1);

    logic [1:0]  cnt;
    logic [31:0] sreg;

    assign word      = {byte_in, sreg[31:8]};
    assign word_full = take && (cnt == LAST);

    // Shift each accepted byte in from the top; the counter wraps per field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 2'd0;
            sreg <= 32'd0;
        end else if (clear) begin
            cnt  <= 2'd0;
            sreg <= 32'd0;
        end else if (take) begin
            cnt  <= cnt + 2'd1;
            sreg <= word;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time loader: reads an entry point, a word count and the data words
// from a byte stream, writes the words to consecutive memory addresses from
// BASE, then releases the core at the entry point.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE     = 32'h0,
    parameter logic [31:0] CAPACITY = 32'h0000ffff
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.master bus
);

    // All header fields and data words share one assembler, so they must
    // agree on length.
    localparam int FIELD_BYTES =
        (ENTRY_BYTES == COUNT_BYTES && COUNT_BYTES == WORD_BYTES) ? WORD_BYTES : 0;

    state_t      state;
    logic [31:0] remaining;
    logic        accepting;
    logic        take;
    logic [31:0] word;
    logic        word_full;

    assign accepting      = (state == ENTRY) || (state == COUNT) || (state == DATA);
    assign bus.byte_ready = accepting && !rst;
    assign take           = bus.byte_ready && bus.byte_valid;

    byte_assembler #(.BYTES(FIELD_BYTES)) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (!accepting),
        .byte_in   (bus.byte_in),
        .take      (take),
        .word      (word),
        .word_full (word_full)
    );

    // Load sequencer: header parsing, one write cycle per word, boot release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ENTRY;
            remaining      <= 32'd0;
            bus.memAddr    <= BASE;
            bus.memIn      <= 32'd0;
            bus.memWrite   <= 1'b0;
            bus.entryPoint <= 32'd0;
            bus.INT        <= 1'b1;
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            case (state)
                ENTRY: begin
                    if (word_full) begin
                        bus.entryPoint <= word;
                        state          <= COUNT;
                    end
                end
                COUNT: begin
                    if (word_full) begin
                        if (bus.entryPoint[1:0] != 2'b00) begin
                            bus.err <= 1'b1;
                            state   <= ERR;
                        end else if (beyond_capacity(BASE, word, CAPACITY)) begin
                            bus.err <= 1'b1;
                            state   <= ERR;
                        end else if (word == 32'd0) begin
                            state <= BOOT;
                        end else begin
                            remaining <= word;
                            state     <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_full) begin
                        bus.memIn    <= word;
                        bus.memWrite <= 1'b1;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    bus.memWrite <= 1'b0;
                    bus.memAddr  <= bus.memAddr + 32'd4;
                    remaining    <= remaining - 32'd1;
                    state        <= (remaining == 32'd1) ? BOOT : DATA;
                end
                BOOT: begin
                    bus.INT  <= 1'b0;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                DONE: state <= DONE;
                ERR:  state <= ERR;
                default: begin
                    bus.err <= 1'b1;
                    state   <= ERR;
                end
            endcase
        end
    end

endmodule
